// File: rtl/lgn_frame_scheduler.sv
// Slot-aligned frame scheduler: round-robin grant of two image sources, frame streaming
// into the LGN classifier on a 32-cycle slot grid, and result capture at a fixed slot.
module lgn_frame_scheduler #(
  parameter int unsigned RESULT_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  output logic        rd_en,
  output logic        rd_src,
  output logic [4:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  lgn_ui,
  output logic        lgn_rst_n,
  input  logic [3:0]  lgn_index,
  input  logic [7:0]  lgn_value,
  output logic        res_valid,
  output logic        res_src,
  output logic [3:0]  res_index,
  output logic [7:0]  res_value,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [4:0] GRANT_SLOT = 5'd29;
  localparam logic [4:0] LAST_SLOT  = 5'd31;
  localparam logic [4:0] RES_SLOT   = 5'(RESULT_SLOT);

  typedef enum logic {IDLE, READ} state_t;

  state_t     state;
  logic [4:0] slot;
  logic       rr_last;
  logic       pend;
  logic       pend_src;
  logic       d_vld, d_src;
  logic       ui_vld, ui_src;
  logic [1:0] gnt;
  logic       gnt_src;

  always_comb begin
    gnt     = '0;
    gnt_src = 1'b0;
    if (!reset && slot == GRANT_SLOT) begin
      unique case (req_valid)
        2'b01:   begin gnt_src = 1'b0;     gnt = 2'b01; end
        2'b10:   begin gnt_src = 1'b1;     gnt = 2'b10; end
        2'b11:   begin gnt_src = ~rr_last; gnt = rr_last ? 2'b01 : 2'b10; end
        default: begin gnt_src = 1'b0;     gnt = 2'b00; end
      endcase
    end
  end

  assign req_ready = gnt;
  assign rd_en     = (state == READ);
  assign rd_addr   = rd_en ? slot + 5'd2 : '0;
  assign lgn_rst_n = ~reset;
  assign busy      = rd_en | pend | ui_vld;

  // Source tag travels with the data (d_* then ui_*) so a back-to-back re-grant,
  // which updates rd_src two slots before the old frame's last byte, cannot mislabel it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      rr_last     <= 1'b1;
      rd_src      <= 1'b0;
      pend        <= 1'b0;
      pend_src    <= 1'b0;
      d_vld       <= 1'b0;
      d_src       <= 1'b0;
      ui_vld      <= 1'b0;
      ui_src      <= 1'b0;
      lgn_ui      <= '0;
      res_valid   <= 1'b0;
      res_src     <= 1'b0;
      res_index   <= '0;
      res_value   <= '0;
      frame_count <= '0;
    end else begin
      slot <= slot + 5'd1;

      if (|gnt) begin
        state   <= READ;
        rd_src  <= gnt_src;
        rr_last <= gnt_src;
      end else if (state == READ && slot == GRANT_SLOT) begin
        state <= IDLE;
      end

      d_vld  <= rd_en;
      d_src  <= rd_src;
      ui_vld <= d_vld;
      ui_src <= d_src;
      lgn_ui <= d_vld ? rd_data : '0;

      res_valid <= 1'b0;
      if (ui_vld && slot == LAST_SLOT) begin
        pend     <= 1'b1;
        pend_src <= ui_src;
      end
      if (pend && slot == RES_SLOT) begin
        pend        <= 1'b0;
        res_valid   <= 1'b1;
        res_src     <= pend_src;
        res_index   <= lgn_index;
        res_value   <= lgn_value;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lgn_frame_scheduler.sv
// Directed bench for lgn_frame_scheduler: single-source vector table, then idle,
// late-request, contention and reset-mid-stream sequences.
module tb_lgn_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic        rd_en, rd_src;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data = '0;
  logic [7:0]  lgn_ui;
  logic        lgn_rst_n;
  logic [3:0]  lgn_index;
  logic [7:0]  lgn_value;
  logic        res_valid, res_src;
  logic [3:0]  res_index;
  logic [7:0]  res_value;
  logic        busy;
  logic [15:0] frame_count;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mode = 1'b0;
  logic [4:0] cyc5;

  lgn_frame_scheduler #(.RESULT_SLOT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rd_en(rd_en), .rd_src(rd_src), .rd_addr(rd_addr), .rd_data(rd_data),
    .lgn_ui(lgn_ui), .lgn_rst_n(lgn_rst_n), .lgn_index(lgn_index),
    .lgn_value(lgn_value), .res_valid(res_valid), .res_src(res_src),
    .res_index(res_index), .res_value(res_value), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // ROM model: one-cycle read latency; idle reads return a poison byte.
  always @(posedge clk)
    rd_data <= rd_en ? ((rd_src ? 8'h80 : 8'h40) + {3'b000, rd_addr}) : 8'hEE;

  assign cyc5      = cyc[4:0];
  assign lgn_index = mode ? cyc5[3:0] : 4'd5;
  assign lgn_value = mode ? (8'hA0 + {3'b000, cyc5}) : 8'hA5;

  typedef struct {
    int          cyc;
    logic [1:0]  req;
    logic [1:0]  rdy;
    logic        en;
    logic [4:0]  addr;
    logic [7:0]  ui;
    logic        busy;
    logic        rv;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int vi;
    logic [1:0] exp_rdy;
    logic [7:0] exp_ui;
    int k;

    vecs[0]  = '{0,  2'b01, 2'b00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{28, 2'b01, 2'b00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{29, 2'b01, 2'b01, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{30, 2'b00, 2'b00, 1'b1, 5'd0,  8'h00, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{31, 2'b00, 2'b00, 1'b1, 5'd1,  8'h00, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{32, 2'b00, 2'b00, 1'b1, 5'd2,  8'h40, 1'b1, 1'b0, 16'd0};
    vecs[6]  = '{33, 2'b00, 2'b00, 1'b1, 5'd3,  8'h41, 1'b1, 1'b0, 16'd0};
    vecs[7]  = '{61, 2'b00, 2'b00, 1'b1, 5'd31, 8'h5D, 1'b1, 1'b0, 16'd0};
    vecs[8]  = '{62, 2'b00, 2'b00, 1'b0, 5'd0,  8'h5E, 1'b1, 1'b0, 16'd0};
    vecs[9]  = '{63, 2'b00, 2'b00, 1'b0, 5'd0,  8'h5F, 1'b1, 1'b0, 16'd0};
    vecs[10] = '{64, 2'b00, 2'b00, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 16'd0};
    vecs[11] = '{65, 2'b00, 2'b00, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 16'd0};
    vecs[12] = '{66, 2'b00, 2'b00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 16'd1};
    vecs[13] = '{67, 2'b00, 2'b00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 16'd1};

    // Single source, table-driven
    mode = 1'b0;
    do_reset();
    vi = 0;
    while (cyc <= 67) begin
      if (vi < 14 && vecs[vi].cyc == cyc) req_valid = vecs[vi].req;
      @(negedge clk);
      if (cyc == 0) chk("rst_n_high", {31'd0, lgn_rst_n}, 32'd1);
      if (vi < 14 && vecs[vi].cyc == cyc) begin
        chk("v_req_ready",   {30'd0, req_ready},   {30'd0, vecs[vi].rdy});
        chk("v_rd_en",       {31'd0, rd_en},       {31'd0, vecs[vi].en});
        chk("v_rd_addr",     {27'd0, rd_addr},     {27'd0, vecs[vi].addr});
        chk("v_lgn_ui",      {24'd0, lgn_ui},      {24'd0, vecs[vi].ui});
        chk("v_busy",        {31'd0, busy},        {31'd0, vecs[vi].busy});
        chk("v_res_valid",   {31'd0, res_valid},   {31'd0, vecs[vi].rv});
        chk("v_frame_count", {16'd0, frame_count}, {16'd0, vecs[vi].fc});
        vi++;
      end
      if (cyc == 30) chk("single_rd_src", {31'd0, rd_src}, 32'd0);
      if (cyc == 66) begin
        chk("single_res_src",   {31'd0, res_src},   32'd0);
        chk("single_res_index", {28'd0, res_index}, 32'd5);
        chk("single_res_value", {24'd0, res_value}, 32'hA5);
      end
      next_cycle();
    end

    // Idle
    do_reset();
    while (cyc < 200) begin
      @(negedge clk);
      chk("idle_quiet", {27'd0, rd_en, req_ready, res_valid, busy}, 32'd0);
      chk("idle_ui", {24'd0, lgn_ui}, 32'd0);
      next_cycle();
    end

    // Late request on source 1 raised at slot 30
    do_reset();
    while (cyc <= 62) begin
      if (cyc == 30) req_valid = 2'b10;
      if (cyc == 62) req_valid = 2'b00;
      @(negedge clk);
      if (cyc == 61) chk("late_grant", {30'd0, req_ready}, 32'd2);
      else chk("late_no_grant", {30'd0, req_ready}, 32'd0);
      if (cyc == 62) begin
        chk("late_rd_src", {31'd0, rd_src}, 32'd1);
        chk("late_rd_en",  {31'd0, rd_en},  32'd1);
      end
      next_cycle();
    end

    // Contention with both sources held
    mode = 1'b1;
    do_reset();
    req_valid = 2'b11;
    while (cyc < 170) begin
      @(negedge clk);
      exp_rdy = 2'b00;
      if (cyc >= 29 && (cyc - 29) % 32 == 0) begin
        k = (cyc - 29) / 32;
        exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
      end
      chk("cont_req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      exp_ui = 8'h00;
      if (cyc >= 32) begin
        k = (cyc - 32) / 32;
        exp_ui = ((k % 2 == 1) ? 8'h80 : 8'h40) + 8'(cyc % 32);
      end
      chk("cont_lgn_ui", {24'd0, lgn_ui}, {24'd0, exp_ui});
      if (cyc >= 66 && (cyc - 66) % 32 == 0) begin
        k = (cyc - 66) / 32;
        chk("cont_res_valid", {31'd0, res_valid}, 32'd1);
        chk("cont_res_src", {31'd0, res_src}, 32'(k % 2));
        chk("cont_res_index", {28'd0, res_index}, 32'd1);
        chk("cont_res_value", {24'd0, res_value}, 32'hA1);
        chk("cont_frame_count", {16'd0, frame_count}, 32'(k + 1));
      end else begin
        chk("cont_no_res", {31'd0, res_valid}, 32'd0);
      end
      next_cycle();
    end

    // Reset asserted at slot 10 of a streaming frame
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_rst_n_low", {31'd0, lgn_rst_n}, 32'd0);
    chk("mid_fc_before", {16'd0, frame_count}, 32'd4);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    req_valid = 2'b11;
    while (cyc <= 64) begin
      if (cyc == 30) req_valid = 2'b00;
      @(negedge clk);
      if (cyc == 0) begin
        chk("mid_ui_zero", {24'd0, lgn_ui}, 32'd0);
        chk("mid_fc_zero", {16'd0, frame_count}, 32'd0);
        chk("mid_busy_zero", {31'd0, busy}, 32'd0);
        chk("mid_rd_en_zero", {31'd0, rd_en}, 32'd0);
      end
      if (cyc == 29) chk("mid_regrant_rr", {30'd0, req_ready}, 32'd1);
      else chk("mid_no_grant", {30'd0, req_ready}, 32'd0);
      chk("mid_no_res", {31'd0, res_valid}, 32'd0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
